// File: rtl/multi_timer.sv
// multi_timer: byte-wide memory-mapped timer with NCH channels,
// each with prescaler, compare, auto-reload/one-shot, sticky flags.
// Ports: clk, rst_ (async low), addr/idata/odata bus, cs_ (low),
//        rw_ (1=read), irq (registered OR of enabled flags).
module multi_timer #(
    parameter int NCH        = 2,
    parameter int CNT_BYTES  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] idata,
    output logic [DATA_WIDTH-1:0] odata,
    input  logic                  cs_,
    input  logic                  rw_,
    output logic                  irq
);

    localparam int CW = 8 * CNT_BYTES;

    logic [31:0] sel32;
    logic [3:0]  off;
    logic        wr_en;
    logic        rd_en;

    assign sel32 = 32'(addr[ADDR_WIDTH-1:4]);
    assign off   = addr[3:0];
    assign wr_en = !cs_ && !rw_;
    assign rd_en = !cs_ && rw_;

    logic [CW-1:0] count_q    [NCH];
    logic [CW-1:0] count_d    [NCH];
    logic [CW-1:0] compare_q  [NCH];
    logic [CW-1:0] compare_d  [NCH];
    logic [7:0]    prescale_q [NCH];
    logic [7:0]    prescale_d [NCH];
    logic [7:0]    precnt_q   [NCH];
    logic [7:0]    precnt_d   [NCH];
    logic [2:0]    mode_q     [NCH];
    logic [2:0]    mode_d     [NCH];
    logic          run_q      [NCH];
    logic          run_d      [NCH];
    logic          match_q    [NCH];
    logic          match_d    [NCH];
    logic          ovf_q      [NCH];
    logic          ovf_d      [NCH];
    logic          irq_q;
    logic          irq_d;

    always_comb begin : next_state
        logic wr_ch;
        logic cmd_wr;
        logic do_clr;
        logic do_start;
        logic do_stop;
        logic tick;
        logic at_cmp;
        logic reload;
        logic hold;
        logic fclr;
        logic match_set;
        logic ovf_set;
        wr_ch     = 1'b0;
        cmd_wr    = 1'b0;
        do_clr    = 1'b0;
        do_start  = 1'b0;
        do_stop   = 1'b0;
        tick      = 1'b0;
        at_cmp    = 1'b0;
        reload    = 1'b0;
        hold      = 1'b0;
        fclr      = 1'b0;
        match_set = 1'b0;
        ovf_set   = 1'b0;
        irq_d     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            count_d[i]    = count_q[i];
            compare_d[i]  = compare_q[i];
            prescale_d[i] = prescale_q[i];
            mode_d[i]     = mode_q[i];
            run_d[i]      = run_q[i];

            wr_ch    = wr_en && (sel32 == 32'(i));
            cmd_wr   = wr_ch && (off == 4'h4);
            do_clr   = cmd_wr && idata[0];
            do_start = cmd_wr && idata[1];
            do_stop  = cmd_wr && idata[2];
            fclr     = wr_ch && (off == 4'h7);

            tick   = run_q[i] && (precnt_q[i] == prescale_q[i]);
            at_cmp = (count_q[i] == compare_q[i]);
            reload = at_cmp && mode_q[i][0];
            // one-shot without reload freezes the count on match
            hold   = at_cmp && mode_q[i][1] && !mode_q[i][0];

            match_set = tick && at_cmp;
            ovf_set   = tick && !reload && !hold && (&count_q[i]);

            if (tick && reload) begin
                count_d[i] = '0;
            end else if (tick && !hold) begin
                count_d[i] = count_q[i] + CW'(1);
            end

            // a byte write replaces the tick update for this cycle
            for (int b = 0; b < CNT_BYTES; b++) begin
                if (wr_ch && (off == 4'(b))) begin
                    count_d[i] = count_q[i];
                    count_d[i][8*b +: 8] = idata[7:0];
                end
                if (wr_ch && (off == 4'(8 + b))) begin
                    compare_d[i][8*b +: 8] = idata[7:0];
                end
            end

            if (do_clr) begin
                count_d[i] = '0;
            end

            if (wr_ch && (off == 4'h5)) begin
                mode_d[i] = idata[2:0];
            end
            if (wr_ch && (off == 4'h6)) begin
                prescale_d[i] = idata[7:0];
            end

            match_d[i] = (match_q[i] && !(fclr && idata[1])) || match_set;
            ovf_d[i]   = (ovf_q[i] && !(fclr && idata[2])) || ovf_set;

            if (tick && at_cmp && mode_q[i][1]) begin
                run_d[i] = 1'b0;
            end
            if (do_start) begin
                run_d[i] = 1'b1;
            end
            if (do_stop) begin
                run_d[i] = 1'b0;
            end

            if (!run_q[i] || tick) begin
                precnt_d[i] = '0;
            end else begin
                precnt_d[i] = precnt_q[i] + 8'd1;
            end
            if (do_clr || do_start || !run_d[i]) begin
                precnt_d[i] = '0;
            end

            irq_d = irq_d || (mode_q[i][2] && (match_q[i] || ovf_q[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i]    <= '0;
                compare_q[i]  <= '1;
                prescale_q[i] <= '0;
                precnt_q[i]   <= '0;
                mode_q[i]     <= '0;
                run_q[i]      <= 1'b0;
                match_q[i]    <= 1'b0;
                ovf_q[i]      <= 1'b0;
            end
            irq_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i]    <= count_d[i];
                compare_q[i]  <= compare_d[i];
                prescale_q[i] <= prescale_d[i];
                precnt_q[i]   <= precnt_d[i];
                mode_q[i]     <= mode_d[i];
                run_q[i]      <= run_d[i];
                match_q[i]    <= match_d[i];
                ovf_q[i]      <= ovf_d[i];
            end
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin : read_mux
        logic [31:0] cnt32;
        logic [31:0] cmp32;
        cnt32 = '0;
        cmp32 = '0;
        odata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_en && (sel32 == 32'(i))) begin
                // zero-extension makes unused upper bytes read 0
                cnt32 = 32'(count_q[i]);
                cmp32 = 32'(compare_q[i]);
                case (off)
                    4'h0, 4'h1, 4'h2, 4'h3:
                        odata = cnt32[8*off[1:0] +: 8];
                    4'h4:
                        odata = {5'b0, ovf_q[i], match_q[i], run_q[i]};
                    4'h5:
                        odata = {5'b0, mode_q[i]};
                    4'h6:
                        odata = prescale_q[i];
                    4'h8, 4'h9, 4'hA, 4'hB:
                        odata = cmp32[8*off[1:0] +: 8];
                    default:
                        odata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed checks of multi_timer, a 4-byte build
// (dut a) and a 1-byte counter build (dut b) on a shared bus.
module tb_multi_timer;

    logic       clk;
    logic       rst_;
    logic [7:0] addr;
    logic [7:0] idata;
    logic [7:0] odata_a;
    logic [7:0] odata_b;
    logic       cs_a;
    logic       cs_b;
    logic       rw_;
    logic       irq_a;
    logic       irq_b;

    int n_chk = 0;
    int n_err = 0;

    multi_timer #(
        .NCH(2), .CNT_BYTES(4), .ADDR_WIDTH(8), .DATA_WIDTH(8)
    ) u_dut_a (
        .clk(clk), .rst_(rst_), .addr(addr), .idata(idata),
        .odata(odata_a), .cs_(cs_a), .rw_(rw_), .irq(irq_a)
    );

    multi_timer #(
        .NCH(2), .CNT_BYTES(1), .ADDR_WIDTH(8), .DATA_WIDTH(8)
    ) u_dut_b (
        .clk(clk), .rst_(rst_), .addr(addr), .idata(idata),
        .odata(odata_b), .cs_(cs_b), .rw_(rw_), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input bit b, input logic [7:0] a,
                          input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        idata = d;
        rw_   = 1'b0;
        if (b) cs_b = 1'b0;
        else   cs_a = 1'b0;
        @(posedge clk);
        #1;
        cs_a = 1'b1;
        cs_b = 1'b1;
        rw_  = 1'b1;
    endtask

    task automatic bus_rd(input bit b, input logic [7:0] a,
                          output logic [7:0] d);
        @(negedge clk);
        addr = a;
        rw_  = 1'b1;
        if (b) cs_b = 1'b0;
        else   cs_a = 1'b0;
        #1;
        d = b ? odata_b : odata_a;
        cs_a = 1'b1;
        cs_b = 1'b1;
    endtask

    task automatic rd_chk(input bit b, input logic [7:0] a,
                          input logic [7:0] exp, input string tag);
        logic [7:0] d;
        bus_rd(b, a, d);
        chk(tag, 32'(d), 32'(exp));
    endtask

    initial begin
        rst_  = 1'b0;
        addr  = '0;
        idata = '0;
        cs_a  = 1'b1;
        cs_b  = 1'b1;
        rw_   = 1'b1;
        repeat (3) @(negedge clk);
        rst_ = 1'b1;

        // reset state of both channels
        for (int c = 0; c < 2; c++) begin
            for (int o = 0; o < 12; o++) begin
                rd_chk(0, 8'((c << 4) | o), (o >= 8) ? 8'hFF : 8'h00,
                       $sformatf("rst ch%0d off%0h", c, o));
            end
        end
        chk("rst irq", 32'(irq_a), 32'd0);

        // ch0 prescale 3: ticks every 4 cycles, 10 ticks before stop
        bus_wr(0, 8'h06, 8'h03);
        bus_wr(0, 8'h04, 8'h02);
        repeat (40) @(posedge clk);
        bus_wr(0, 8'h04, 8'h04);
        rd_chk(0, 8'h00, 8'd10, "presc count");
        rd_chk(0, 8'h04, 8'h00, "presc stopped");
        repeat (20) @(negedge clk);
        rd_chk(0, 8'h00, 8'd10, "presc hold");

        // ch1 autoreload at 5 with irq
        bus_wr(0, 8'h18, 8'h05);
        bus_wr(0, 8'h19, 8'h00);
        bus_wr(0, 8'h1A, 8'h00);
        bus_wr(0, 8'h1B, 8'h00);
        bus_wr(0, 8'h15, 8'h05);
        bus_wr(0, 8'h16, 8'h00);
        bus_wr(0, 8'h14, 8'h02);
        for (int i = 0; i < 12; i++) begin
            rd_chk(0, 8'h10, 8'(i % 6), $sformatf("ar seq%0d", i));
            chk($sformatf("ar irq%0d", i), 32'(irq_a), 32'(i >= 7));
        end
        bus_wr(0, 8'h17, 8'h02);
        @(negedge clk);
        @(negedge clk);
        #1 chk("irq clr", 32'(irq_a), 32'd0);
        repeat (4) @(negedge clk);
        #1 chk("irq pre wrap", 32'(irq_a), 32'd0);
        @(negedge clk);
        #1 chk("irq rewrap", 32'(irq_a), 32'd1);
        bus_wr(0, 8'h14, 8'h04);
        bus_wr(0, 8'h17, 8'h06);
        bus_wr(0, 8'h15, 8'h00);

        // 1-byte counter: overflow, then one-shot compare
        bus_wr(1, 8'h00, 8'hFE);
        bus_wr(1, 8'h04, 8'h02);
        repeat (2) @(negedge clk);
        rd_chk(1, 8'h00, 8'h00, "b8 wrap");
        rd_chk(1, 8'h04, 8'h07, "b8 ovf stat");
        bus_wr(1, 8'h04, 8'h04);
        bus_wr(1, 8'h07, 8'h06);
        bus_wr(1, 8'h08, 8'h10);
        bus_wr(1, 8'h05, 8'h02);
        bus_wr(1, 8'h00, 8'h0C);
        bus_wr(1, 8'h04, 8'h02);
        repeat (10) @(negedge clk);
        rd_chk(1, 8'h00, 8'h10, "b8 oneshot");
        rd_chk(1, 8'h04, 8'h02, "b8 os stat");
        bus_wr(1, 8'h01, 8'hAA);
        rd_chk(1, 8'h01, 8'h00, "b8 hi byte");
        rd_chk(1, 8'h09, 8'h00, "b8 cmp hi");

        // clear+start, then start+stop
        bus_wr(0, 8'h00, 8'h34);
        bus_wr(0, 8'h01, 8'h12);
        rd_chk(0, 8'h00, 8'h34, "cnt b0 wr");
        rd_chk(0, 8'h01, 8'h12, "cnt b1 wr");
        bus_wr(0, 8'h04, 8'h03);
        rd_chk(0, 8'h00, 8'h00, "clrstart cnt");
        rd_chk(0, 8'h04, 8'h01, "clrstart run");
        bus_wr(0, 8'h04, 8'h06);
        rd_chk(0, 8'h04, 8'h00, "stop wins");
        rd_chk(0, 8'h01, 8'h00, "clr b1");

        // match set coincident with FLAGCLR
        bus_wr(0, 8'h10, 8'h05);
        bus_wr(0, 8'h14, 8'h02);
        bus_wr(0, 8'h17, 8'h02);
        rd_chk(0, 8'h14, 8'h03, "set beats clr");
        bus_wr(0, 8'h14, 8'h04);

        // channel index NCH is absent
        bus_wr(0, 8'h20, 8'h55);
        bus_wr(0, 8'h25, 8'h07);
        bus_wr(0, 8'h26, 8'h09);
        bus_wr(0, 8'h24, 8'h02);
        rd_chk(0, 8'h20, 8'h00, "nch cnt");
        rd_chk(0, 8'h25, 8'h00, "nch mode");
        rd_chk(0, 8'h26, 8'h00, "nch presc");
        rd_chk(0, 8'h00, 8'h00, "nch ch0 cnt");
        rd_chk(0, 8'h04, 8'h00, "nch ch0 stat");
        rd_chk(0, 8'h05, 8'h00, "nch ch0 mode");
        rd_chk(0, 8'h06, 8'h03, "nch ch0 presc");
        rd_chk(0, 8'h15, 8'h00, "nch ch1 mode");
        rd_chk(0, 8'h14, 8'h02, "nch ch1 stat");
        rd_chk(0, 8'h0C, 8'h00, "reserved");

        // async reset while running with irq high
        bus_wr(0, 8'h06, 8'h00);
        bus_wr(0, 8'h08, 8'h02);
        bus_wr(0, 8'h09, 8'h00);
        bus_wr(0, 8'h0A, 8'h00);
        bus_wr(0, 8'h0B, 8'h00);
        bus_wr(0, 8'h05, 8'h04);
        bus_wr(0, 8'h04, 8'h03);
        repeat (6) @(negedge clk);
        #1 chk("pre rst irq", 32'(irq_a), 32'd1);
        @(posedge clk);
        #3 rst_ = 1'b0;
        #1 chk("arst irq", 32'(irq_a), 32'd0);
        rw_  = 1'b1;
        cs_a = 1'b0;
        addr = 8'h00;
        #1 chk("arst cnt", 32'(odata_a), 32'd0);
        addr = 8'h04;
        #1 chk("arst stat", 32'(odata_a), 32'd0);
        addr = 8'h05;
        #1 chk("arst mode", 32'(odata_a), 32'd0);
        addr = 8'h08;
        #1 chk("arst cmp", 32'(odata_a), 32'hFF);
        addr = 8'h14;
        #1 chk("arst ch1 stat", 32'(odata_a), 32'd0);
        cs_a = 1'b1;
        chk("irq b", 32'(irq_b), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
